// File: rtl/line_window_feeder_if.sv
// ============================================================================
// line_window_feeder_if : pixel-in / window-column-out bus for line_window_feeder
// Revision : 1.0
// ============================================================================
`default_nettype none

interface line_window_feeder_if #(
  parameter int DATA_W = 1
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_top;
  logic [DATA_W-1:0] m_mid;
  logic [DATA_W-1:0] m_bot;
  logic [5:0]        m_x;
  logic [5:0]        m_y;
  logic              m_eof;

  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_top, m_mid, m_bot, m_x, m_y, m_eof
  );

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_top, m_mid, m_bot, m_x, m_y, m_eof
  );
endinterface

`default_nettype wire

// File: rtl/line_window_feeder.sv
// ============================================================================
// line_window_feeder : turns a raster pixel stream into 3-tall window columns
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_window_feeder #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 1
) (
  input  wire                  clk,
  input  wire                  rst_n,
  line_window_feeder_if.slave  bus
);

  localparam int         AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [5:0] X_LAST = 6'(IMG_W - 1);
  localparam logic [5:0] Y_LAST = 6'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        x_q, x_d;
  logic [5:0]        y_q, y_d;
  logic              sel_q, sel_d;
  logic              m_valid_q, m_valid_d;
  logic              m_eof_q, m_eof_d;
  logic [DATA_W-1:0] m_top_q, m_top_d;
  logic [DATA_W-1:0] m_mid_q, m_mid_d;
  logic [DATA_W-1:0] m_bot_q, m_bot_d;
  logic [5:0]        m_x_q, m_x_d;
  logic [5:0]        m_y_q, m_y_d;

  // sel_q=0: buf0 holds line y-1, buf1 holds line y-2 (and is overwritten)
  logic [DATA_W-1:0] buf0_q [IMG_W];
  logic [DATA_W-1:0] buf1_q [IMG_W];

  logic              w_s_ready;
  logic              w_accept;
  logic              w_last_x;
  logic              w_wr_en;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     w_wr_idx;
  logic [DATA_W-1:0] w_newer;
  logic [DATA_W-1:0] w_older;

  assign w_s_ready = !m_valid_q || bus.m_ready;
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_last_x  = (x_q == X_LAST);
  assign w_idx     = x_q[AW-1:0];
  assign w_wr_idx  = bus.s_sof ? '0 : w_idx;
  assign w_wr_en   = w_accept && (bus.s_sof || (state_q != ST_IDLE));
  assign w_newer   = sel_q ? buf1_q[w_idx] : buf0_q[w_idx];
  assign w_older   = sel_q ? buf0_q[w_idx] : buf1_q[w_idx];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (sel_q) buf0_q[w_wr_idx] <= bus.s_data;
      else       buf1_q[w_wr_idx] <= bus.s_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sel_d     = sel_q;
    m_valid_d = m_valid_q && !bus.m_ready;
    m_eof_d   = m_eof_q;
    m_top_d   = m_top_q;
    m_mid_d   = m_mid_q;
    m_bot_d   = m_bot_q;
    m_x_d     = m_x_q;
    m_y_d     = m_y_q;

    if (w_accept) begin
      if (bus.s_sof) begin
        state_d = ST_PRIME;
        x_d     = 6'd1;
        y_d     = 6'd0;
      end else if (state_q != ST_IDLE) begin
        if (w_last_x) begin
          x_d   = 6'd0;
          y_d   = y_q + 6'd1;
          sel_d = ~sel_q;
        end else begin
          x_d = x_q + 6'd1;
        end

        case (state_q)
          ST_PRIME: begin
            if (w_last_x && (y_q == 6'd1)) state_d = ST_STREAM;
          end
          ST_STREAM: begin
            m_valid_d = 1'b1;
            m_top_d   = w_older;
            m_mid_d   = w_newer;
            m_bot_d   = bus.s_data;
            m_x_d     = x_q;
            m_y_d     = y_q;
            m_eof_d   = w_last_x && (y_q == Y_LAST);
            if (w_last_x && (y_q == Y_LAST)) begin
              state_d = ST_IDLE;
              y_d     = 6'd0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= 6'd0;
      y_q       <= 6'd0;
      sel_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_eof_q   <= 1'b0;
      m_top_q   <= '0;
      m_mid_q   <= '0;
      m_bot_q   <= '0;
      m_x_q     <= 6'd0;
      m_y_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
      m_valid_q <= m_valid_d;
      m_eof_q   <= m_eof_d;
      m_top_q   <= m_top_d;
      m_mid_q   <= m_mid_d;
      m_bot_q   <= m_bot_d;
      m_x_q     <= m_x_d;
      m_y_q     <= m_y_d;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_eof   = m_eof_q;
  assign bus.m_top   = m_top_q;
  assign bus.m_mid   = m_mid_q;
  assign bus.m_bot   = m_bot_q;
  assign bus.m_x     = m_x_q;
  assign bus.m_y     = m_y_q;

endmodule

`default_nettype wire

// File: tb/tb_line_window_feeder.sv
// ============================================================================
// tb_line_window_feeder : directed self-checking bench for line_window_feeder
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_line_window_feeder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  line_window_feeder_if #(.DATA_W(1)) ifc ();

  line_window_feeder #(.IMG_W(8), .IMG_H(8), .DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a column handshakes on the next rising edge when seen valid/ready here
  always @(negedge clk) begin
    if (rst_n && ifc.m_valid && ifc.m_ready)
      got_q.push_back({ifc.m_eof, ifc.m_y, ifc.m_x, ifc.m_top, ifc.m_mid, ifc.m_bot});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 1'b1;
      1:       return 1'((y & 1) != 0);
      default: return 1'(((x & 1) ^ ((y >> 1) & 1)) != 0);
    endcase
  endfunction

  function automatic logic [15:0] col(input int pat, input int x, input int y);
    return {((x == 7) && (y == 7)), 6'(y), 6'(x),
            pix(pat, x, y - 2), pix(pat, x, y - 1), pix(pat, x, y)};
  endfunction

  task automatic send_px(input logic d, input logic sof);
    int   n;
    logic rdy;
    n = 0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_sof   = sof;
    do begin
      @(negedge clk);
      rdy = ifc.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
    ifc.s_valid = 1'b0;
    ifc.s_sof   = 1'b0;
  endtask

  // raster indices [lo, hi) of an 8x8 frame; index 0 carries s_sof
  task automatic send_range(input int pat, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      send_px(pix(pat, i % 8, i / 8), i == 0);
      if (i == 15) check("lat_prime", {31'd0, ifc.m_valid}, 32'd0);
      if (i == 16) check("lat_first", {31'd0, ifc.m_valid}, 32'd1);
    end
  endtask

  task automatic expect_range(input int pat, input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      if (i >= 16) exp_q.push_back(col(pat, i % 8, i / 8));
  endtask

  task automatic compare_cols();
    repeat (3) @(posedge clk);
    #1;
    check("ncols", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("col%0d", i), {16'd0, got_q[i]}, {16'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] snap;
    int          n;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = 1'b0;
    ifc.s_sof   = 1'b0;
    ifc.m_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", {31'd0, ifc.m_valid}, 32'd0);
    check("rst_sready", {31'd0, ifc.s_ready}, 32'd1);
    check("rst_outs", {16'd0, ifc.m_eof, ifc.m_y, ifc.m_x, ifc.m_top, ifc.m_mid, ifc.m_bot}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // all-ones frame
    got_q.delete();
    send_range(0, 0, 64);
    expect_range(0, 0, 64);
    compare_cols();

    // alternating-line frame
    send_range(1, 0, 64);
    expect_range(1, 0, 64);
    compare_cols();

    // downstream stall mid-line
    fork
      begin
        send_range(2, 0, 64);
      end
      begin
        n = 0;
        while (got_q.size() < 20 && n < 2000) begin
          @(posedge clk);
          #1;
          n++;
        end
        ifc.m_ready = 1'b0;
        snap = {ifc.m_eof, ifc.m_y, ifc.m_x, ifc.m_top, ifc.m_mid, ifc.m_bot};
        check("stall_mvalid", {31'd0, ifc.m_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_sready", {31'd0, ifc.s_ready}, 32'd0);
          check("stall_hold", {16'd0, ifc.m_eof, ifc.m_y, ifc.m_x, ifc.m_top, ifc.m_mid, ifc.m_bot},
                {16'd0, snap});
        end
        @(posedge clk);
        #1;
        ifc.m_ready = 1'b1;
      end
    join
    expect_range(2, 0, 64);
    compare_cols();

    // non-sof junk in IDLE is dropped
    for (int k = 0; k < 3; k++) send_px(1'b1, 1'b0);
    check("junk_mvalid", {31'd0, ifc.m_valid}, 32'd0);
    send_range(1, 0, 64);
    expect_range(1, 0, 64);
    compare_cols();

    // restart on s_sof at (3,4)
    send_range(1, 0, 35);
    send_range(2, 0, 1);
    check("restart_mvalid", {31'd0, ifc.m_valid}, 32'd0);
    send_range(2, 1, 64);
    expect_range(1, 0, 35);
    expect_range(2, 0, 64);
    compare_cols();

    // asynchronous reset while streaming at (5,5)
    send_range(2, 0, 46);
    check("pre_rst_mvalid", {31'd0, ifc.m_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mvalid", {31'd0, ifc.m_valid}, 32'd0);
    check("arst_sready", {31'd0, ifc.s_ready}, 32'd1);
    check("arst_xy", {20'd0, ifc.m_y, ifc.m_x}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    send_range(1, 0, 64);
    expect_range(1, 0, 64);
    compare_cols();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_window_feeder.md
LINE_WINDOW_FEEDER -- requirements
Module: line_window_feeder

Interface
REQ-001 The block SHALL have parameter IMG_W, default 8, meaning pixels per line (2..64).
REQ-002 The block SHALL have parameter IMG_H, default 8, meaning lines per frame (3..64).
REQ-003 The block SHALL have parameter DATA_W, default 1, meaning bits per pixel.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port s_valid, input, 1 bit: input pixel valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit: block can accept a pixel.
REQ-009 The block SHALL have port s_data, input, DATA_W bits: raster-order pixel.
REQ-010 The block SHALL have port s_sof, input, 1 bit: s_data is pixel (0,0) of a frame.
REQ-011 The block SHALL have port m_valid, output, 1 bit: window column valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: downstream accepts the column.
REQ-013 The block SHALL have ports m_top, m_mid and m_bot, outputs, DATA_W bits each: pixel (x,y-2), pixel (x,y-1) and pixel (x,y).
REQ-014 The block SHALL have ports m_x and m_y, outputs, 6 bits each: column and line of m_bot.
REQ-015 The block SHALL have port m_eof, output, 1 bit: column holds the last pixel of the frame.

Function
REQ-016 A pixel SHALL be accepted exactly when s_valid and s_ready are both 1 on a rising edge.
REQ-017 The output handshake SHALL complete exactly when m_valid and m_ready are both 1 on a rising edge.
REQ-018 s_ready SHALL equal (!m_valid || m_ready), combinationally.
REQ-019 The block SHALL hold two internal line buffers, each IMG_W x DATA_W, holding lines y-1 (newer) and y-2 (older).
REQ-020 On an accepted pixel at column x, the block SHALL read both buffers at x and then overwrite the older buffer at x with s_data (read-before-write in the same cycle).
REQ-021 When x wraps, the block SHALL toggle the newer/older buffer roles.
REQ-022 The FSM SHALL have states IDLE, PRIME and STREAM.
REQ-023 In IDLE, accepted pixels with s_sof=0 SHALL be discarded.
REQ-024 In IDLE, an accepted pixel with s_sof=1 SHALL be written as (0,0), and the FSM SHALL move to PRIME.
REQ-025 In PRIME (lines 0-1), pixels SHALL be stored and m_valid SHALL stay 0.
REQ-026 The FSM SHALL leave PRIME for STREAM when the pixel (IMG_W-1, 1) is accepted.
REQ-027 In STREAM, each accepted pixel SHALL load m_top, m_mid, m_bot, m_x, m_y and m_eof registers and set m_valid the next cycle, giving 1-cycle latency.
REQ-028 m_valid SHALL clear after an output handshake unless a new pixel is accepted in the same cycle.
REQ-029 The x counter SHALL increment per accepted pixel and wrap from IMG_W-1 to 0, and y SHALL increment on each wrap.
REQ-030 On accepting (IMG_W-1, IMG_H-1), the block SHALL set m_eof=1 with that column and the FSM SHALL return to IDLE.
REQ-031 An accepted s_sof=1 in PRIME or STREAM SHALL restart the frame: x=0, y=0, state PRIME, pixel stored at (0,0); a pending m_valid column SHALL still be delivered.
REQ-032 While m_valid=1 and m_ready=0, all m_* outputs SHALL stay stable.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately set m_valid=0, m_eof=0, m_top/m_mid/m_bot=0, m_x=0, m_y=0, x=0, y=0, buffer select=0 and state IDLE, at any point including mid-frame.
REQ-034 Line buffer contents SHALL NOT be reset; no output SHALL depend on them before PRIME completes.
REQ-035 While in reset, s_ready SHALL read 1.

Verification
REQ-036 Reset, then send an 8x8 all-ones frame with m_ready=1 -> first m_valid one cycle after pixel (0,2), with m_top=m_mid=m_bot=1; 48 columns total; m_eof only on (7,7).
REQ-037 Send a frame where pixel value = y[0] -> every column has m_top=m_bot, m_mid=!m_bot, and m_y matches the line.
REQ-038 Hold m_ready=0 for 5 cycles mid-line -> s_ready=0 and outputs stable throughout; no pixel lost or duplicated once m_ready returns.
REQ-039 Send 3 pixels with s_sof=0 in IDLE, then a frame -> the 3 pixels are discarded and output matches a clean frame.
REQ-040 Assert s_sof at (3,4) -> restart; next m_valid only after new line 2 pixel 0, with m_x=0 and m_y=2.
REQ-041 Pulse rst_n low during STREAM at (5,5) -> m_valid drops within the same cycle, state IDLE, and the next frame streams correctly.
